// File: rtl/fe_mul_arbiter.sv
// fe_mul_arbiter: shares one fe_mulx field multiplier between N_REQ requesters.
// Round-robin grant, one multiplication outstanding at a time, and each
// product is returned only to the requester that issued it. All outputs
// are registered.
module fe_mul_arbiter #(
  parameter int N_REQ = 2,
  parameter int W     = 320,
  parameter int CNT_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*W-1:0]         req_op_a,
  input  logic [N_REQ*W-1:0]         req_op_b,
  output logic [N_REQ-1:0]           req_done,
  output logic [W-1:0]               req_res,
  output logic [W-1:0]               mul_op_a,
  output logic [W-1:0]               mul_op_b,
  output logic                       mul_valid,
  input  logic [W-1:0]               mul_res,
  input  logic                       mul_done,
  output logic                       busy,
  output logic [$clog2(N_REQ)-1:0]   grant,
  output logic [CNT_W-1:0]           mul_count
);

  localparam int GW = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t             state, state_d;
  logic [W-1:0]       op_a_d, op_b_d, res_d;
  logic               valid_d, busy_d;
  logic [N_REQ-1:0]   done_d;
  logic [GW-1:0]      grant_d;
  logic [CNT_W-1:0]   count_d;

  logic               found;
  logic [GW-1:0]      pick, cand;

  // Round-robin search: first active requester after the last grant, wrapping.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so no
    // path leaves it unassigned; that is what keeps latches from being inferred.
    found = 1'b0;
    pick  = grant;
    cand  = grant;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = GW'((int'(grant) + k) % N_REQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Next-state and next-output logic; registers hold unless a state says otherwise.
  always_comb begin
    state_d = state;
    op_a_d  = mul_op_a;
    op_b_d  = mul_op_b;
    res_d   = req_res;
    valid_d = 1'b0;
    done_d  = '0;
    grant_d = grant;
    count_d = mul_count;
    unique case (state)
      IDLE: begin
        if (found) begin
          op_a_d  = req_op_a[int'(pick)*W +: W];
          op_b_d  = req_op_b[int'(pick)*W +: W];
          grant_d = pick;
          valid_d = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // The start pulse is on the wire this cycle; a done now would be stale.
        state_d = WAIT;
      end
      WAIT: begin
        if (mul_done) begin
          res_d         = mul_res;
          done_d[grant] = 1'b1;
          state_d       = DONE;
        end
      end
      DONE: begin
        count_d = mul_count + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; synchronous reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state     <= IDLE;
      mul_op_a  <= '0;
      mul_op_b  <= '0;
      req_res   <= '0;
      mul_valid <= 1'b0;
      req_done  <= '0;
      busy      <= 1'b0;
      grant     <= GW'(N_REQ - 1);
      mul_count <= '0;
    end else begin
      state     <= state_d;
      mul_op_a  <= op_a_d;
      mul_op_b  <= op_b_d;
      req_res   <= res_d;
      mul_valid <= valid_d;
      req_done  <= done_d;
      busy      <= busy_d;
      grant     <= grant_d;
      mul_count <= count_d;
    end
  end

endmodule

// File: tb/tb_fe_mul_arbiter.sv
// Self-checking bench for fe_mul_arbiter with a behavioural fe_mulx stub of
// configurable latency and done-hold length.
module tb_fe_mul_arbiter;

  localparam int N_REQ = 2;
  localparam int W     = 320;
  localparam int CNT_W = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [N_REQ-1:0]     req_valid = '0;
  logic [N_REQ*W-1:0]   req_op_a = '0;
  logic [N_REQ*W-1:0]   req_op_b = '0;
  logic [N_REQ-1:0]     req_done;
  logic [W-1:0]         req_res;
  logic [W-1:0]         mul_op_a;
  logic [W-1:0]         mul_op_b;
  logic                 mul_valid;
  logic [W-1:0]         mul_res = '0;
  logic                 mul_done = 1'b0;
  logic                 busy;
  logic [0:0]           grant;
  logic [CNT_W-1:0]     mul_count;

  int total = 0;
  int bad   = 0;

  fe_mul_arbiter #(.N_REQ(N_REQ), .W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_op_a(req_op_a), .req_op_b(req_op_b),
    .req_done(req_done), .req_res(req_res),
    .mul_op_a(mul_op_a), .mul_op_b(mul_op_b), .mul_valid(mul_valid),
    .mul_res(mul_res), .mul_done(mul_done),
    .busy(busy), .grant(grant), .mul_count(mul_count)
  );

  always #5 clk = ~clk;

  // Multiplier stub: done rises stub_lat cycles after the start pulse and stays
  // high for stub_hold cycles; res carries noise outside that window.
  int cyc = 0;
  int stub_start = 1;
  int stub_end = 0;
  int stub_lat = 1;
  int stub_hold = 1;
  logic [W-1:0] stub_prod = '0;
  always @(posedge clk) begin
    if (mul_valid) begin
      stub_start = cyc + stub_lat;
      stub_end   = stub_start + stub_hold - 1;
      stub_prod  = mul_op_a * mul_op_b;
    end
    mul_done <= (cyc + 1 >= stub_start) && (cyc + 1 <= stub_end);
    mul_res  <= ((cyc + 1 >= stub_start) && (cyc + 1 <= stub_end)) ? stub_prod : {10{$urandom}};
    cyc <= cyc + 1;
  end

  task automatic check(input bit ok, input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pulse-shape monitor: req_done one-hot and one cycle wide, mul_valid one cycle wide.
  logic [N_REQ-1:0] prev_done = '0;
  logic             prev_valid = 1'b0;
  int               done_seen = 0;
  always @(negedge clk) begin
    if (prev_done != '0) check(req_done == '0, "done_pulse_width", W'(req_done), '0);
    if (req_done != '0) begin
      check($onehot(req_done), "done_onehot", W'(req_done), W'(1));
      done_seen++;
    end
    if (prev_valid) check(!mul_valid, "valid_pulse_width", W'(mul_valid), '0);
    prev_done  = req_done;
    prev_valid = mul_valid;
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Presents one request set and follows the granted operation to its done pulse.
  task automatic do_op(input logic [1:0] mask, input logic [W-1:0] a0, input logic [W-1:0] b0,
                       input logic [W-1:0] a1, input logic [W-1:0] b1, input int lat, input int hold,
                       input int exp_g, input logic [W-1:0] exp_res, output int n_valid);
    int n;
    int m;
    stub_lat  = lat;
    stub_hold = hold;
    req_valid = mask;
    req_op_a  = {a1, a0};
    req_op_b  = {b1, b0};
    n = 0;
    do begin @(negedge clk); n++; end while (!mul_valid && n < 8);
    n_valid = n;
    check(mul_valid == 1'b1, "valid_seen", W'(mul_valid), W'(1));
    if (!mul_valid) return;
    check(grant == 1'(exp_g), "grant", W'(grant), W'(exp_g));
    check(mul_op_a == (exp_g == 1 ? a1 : a0), "mul_op_a", mul_op_a, exp_g == 1 ? a1 : a0);
    check(mul_op_b == (exp_g == 1 ? b1 : b0), "mul_op_b", mul_op_b, exp_g == 1 ? b1 : b0);
    m = 0;
    do begin @(negedge clk); m++; end while (req_done == '0 && m < lat + 6);
    check(m == lat + 1, "done_latency", W'(m), W'(lat + 1));
    check(req_done == (2'b01 << exp_g), "done_mask", W'(req_done), W'(2'b01 << exp_g));
    check(req_res == exp_res, "req_res", req_res, exp_res);
  endtask

  function automatic logic [W-1:0] rnd_fe();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  typedef struct {
    logic [1:0]   mask;
    logic [W-1:0] a0, b0, a1, b1;
    int           lat, hold, exp_g;
    logic [W-1:0] exp_res;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] ones;
    logic [W-1:0] ra0, rb0, ra1, rb1, exp;
    logic [1:0]   mask;
    int           nv, last_g, g, model_cnt, seen0;
    ones = '1;

    // Simultaneous requests then continuous contention, boundary operands, long latency, held done.
    vecs[0] = '{2'b11, W'(2), W'(3), W'(5), W'(7), 1,  1, 0, W'(6)};
    vecs[1] = '{2'b11, W'(2), W'(3), W'(5), W'(7), 20, 1, 1, W'(35)};
    vecs[2] = '{2'b11, W'(2), W'(3), W'(5), W'(7), 1,  3, 0, W'(6)};
    vecs[3] = '{2'b11, W'(2), W'(3), W'(5), W'(7), 3,  2, 1, W'(35)};
    vecs[4] = '{2'b11, W'(2), W'(3), W'(5), W'(7), 2,  1, 0, W'(6)};
    vecs[5] = '{2'b11, W'(2), W'(3), W'(5), W'(7), 1,  1, 1, W'(35)};
    vecs[6] = '{2'b10, W'(4), W'(4), W'(9), W'(9), 1,  1, 1, W'(81)};
    vecs[7] = '{2'b01, W'(0), W'(65535), W'(9), W'(9), 2, 1, 0, W'(0)};
    vecs[8] = '{2'b10, W'(1), W'(1), ones, W'(2), 1,  1, 1, ones - W'(1)};
    vecs[9] = '{2'b01, ones, ones, W'(3), W'(3), 4,  1, 0, W'(1)};

    // Reset state.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check(req_done == '0 && mul_valid == 1'b0 && busy == 1'b0, "reset_ctl", W'({req_done, mul_valid, busy}), '0);
    check(mul_op_a == '0 && mul_op_b == '0 && req_res == '0, "reset_data", mul_op_a | mul_op_b | req_res, '0);
    check(grant == 1'(N_REQ - 1), "reset_grant", W'(grant), W'(N_REQ - 1));
    check(mul_count == '0, "reset_count", W'(mul_count), '0);

    // Single request from IDLE.
    do_op(2'b01, W'(2), W'(3), W'(0), W'(0), 1, 1, 0, W'(6), nv);
    check(nv == 1, "issue_latency", W'(nv), W'(1));
    req_valid = '0;
    repeat (2) @(negedge clk);
    check(busy == 1'b0, "single_busy", W'(busy), '0);
    check(mul_count == 4'd1, "single_count", W'(mul_count), W'(1));
    check(req_res == W'(6), "res_holds", req_res, W'(6));

    // Table: simultaneous / contention / corner operands.
    do_reset();
    for (int i = 0; i < 10; i++)
      do_op(vecs[i].mask, vecs[i].a0, vecs[i].b0, vecs[i].a1, vecs[i].b1,
            vecs[i].lat, vecs[i].hold, vecs[i].exp_g, vecs[i].exp_res, nv);
    req_valid = '0;
    repeat (3) @(negedge clk);
    check(mul_count == 4'd10, "table_count", W'(mul_count), W'(10));

    // Reset while in WAIT; the late mul_done must be ignored.
    do_reset();
    stub_lat = 10;
    stub_hold = 1;
    req_valid = 2'b01;
    req_op_a = {W'(0), W'(11)};
    req_op_b = {W'(0), W'(13)};
    repeat (4) @(negedge clk);
    rst = 1'b1;
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    seen0 = done_seen;
    check(req_done == '0 && mul_valid == 1'b0 && busy == 1'b0, "midrst_ctl", W'({req_done, mul_valid, busy}), '0);
    check(mul_op_a == '0 && mul_op_b == '0 && req_res == '0, "midrst_data", mul_op_a | mul_op_b | req_res, '0);
    check(grant == 1'(N_REQ - 1), "midrst_grant", W'(grant), W'(N_REQ - 1));
    repeat (15) @(negedge clk);
    check(done_seen == seen0, "midrst_no_done", W'(done_seen - seen0), '0);
    check(mul_count == '0 && busy == 1'b0, "midrst_count", W'({mul_count, busy}), '0);

    // Random traffic against a round-robin reference model.
    do_reset();
    last_g = N_REQ - 1;
    model_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      mask = (i < 17) ? 2'($urandom_range(1, 3)) : 2'($urandom_range(0, 3));
      if (mask == 2'b00) begin
        req_valid = '0;
        repeat ($urandom_range(2, 3)) @(negedge clk);
        check(busy == 1'b0 && mul_valid == 1'b0, "rand_idle", W'({busy, mul_valid}), '0);
        continue;
      end
      g = -1;
      for (int k = 1; k <= N_REQ; k++)
        if (g < 0 && mask[(last_g + k) % N_REQ]) g = (last_g + k) % N_REQ;
      ra0 = ($urandom_range(0, 3) == 0) ? W'($urandom) : rnd_fe();
      rb0 = rnd_fe();
      ra1 = rnd_fe();
      rb1 = ($urandom_range(0, 3) == 0) ? ones : rnd_fe();
      exp = (g == 1) ? ra1 * rb1 : ra0 * rb0;
      do_op(mask, ra0, rb0, ra1, rb1, $urandom_range(1, 6), $urandom_range(1, 3), g, exp, nv);
      last_g = g;
      model_cnt++;
      if (model_cnt == 17) begin
        req_valid = '0;
        repeat (2) @(negedge clk);
        check(mul_count == 4'd1, "count_wrap", W'(mul_count), W'(1));
      end
    end
    req_valid = '0;
    repeat (3) @(negedge clk);
    check(mul_count == CNT_W'(model_cnt), "rand_count", W'(mul_count), W'(CNT_W'(model_cnt)));
    check(busy == 1'b0, "final_busy", W'(busy), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
